// File: rtl/playfield_engine_if.sv
// Piece-generator link: the engine requests a piece; the generator answers
// with a 4x4 mask qualified by valid.
interface playfield_engine_if;
    logic [15:0] piece_mask;
    logic        piece_valid;
    logic        piece_req;

    modport master (output piece_mask, output piece_valid, input  piece_req);
    modport slave  (input  piece_mask, input  piece_valid, output piece_req);
endinterface

// File: rtl/playfield_engine.sv
// Tetris playfield: stored grid plus one active 4x4 piece, running the
// spawn -> fall -> lock -> line-clear loop.
module playfield_engine #(
    parameter int ROWS      = 20,
    parameter int COLS      = 10,
    parameter int SPAWN_COL = 3,
    parameter int LINES_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     tick,
    input  logic                     left_i,
    input  logic                     right_i,
    input  logic                     drop_i,
    playfield_engine_if.slave        pif,
    output logic [ROWS*COLS-1:0]     display,
    output logic [LINES_W-1:0]       lines_cleared,
    output logic                     gameover,
    output logic [2:0]               state_o
);
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(COLS) + 2;
    localparam int RW = $clog2(ROWS) + 1;
    localparam int SW = $clog2(ROWS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPAWN    = 3'd1,
        S_FALL     = 3'd2,
        S_LOCK     = 3'd3,
        S_CLEAR    = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    state_t                 r_state;
    logic [N-1:0]           r_grid;
    logic [15:0]            r_mask;
    logic [RW-1:0]          r_row;
    logic signed [CW-1:0]   r_col;
    logic                   r_drop;
    logic                   r_pend;
    logic [SW-1:0]          r_scan;
    logic [LINES_W-1:0]     r_lines;

    state_t                 w_state_n;
    logic [N-1:0]           w_grid_n;
    logic [15:0]            w_mask_n;
    logic [RW-1:0]          w_row_n;
    logic signed [CW-1:0]   w_col_n;
    logic                   w_drop_n;
    logic                   w_pend_n;
    logic [SW-1:0]          w_scan_n;
    logic [LINES_W-1:0]     w_lines_n;

    logic [N-1:0]           w_active;
    logic [N-1:0]           w_shifted;
    logic                   w_fit_spawn;
    logic                   w_fit_down;
    logic                   w_fit_left;
    logic                   w_fit_right;
    logic                   w_row_full;

    // Set mask bits must land inside the field on empty cells; zero bits may overhang.
    function automatic logic f_fits(input logic [15:0] m, input int row, input int col,
                                    input logic [N-1:0] g);
        logic ok;
        int   rr;
        int   cc;
        ok = 1'b1;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (m[r*4+c]) begin
                    rr = row + int'(r);
                    cc = col + int'(c);
                    if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS)
                        ok = 1'b0;
                    else if (g[rr*COLS+cc])
                        ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    function automatic logic [N-1:0] f_render(input logic [15:0] m, input int row, input int col);
        logic [N-1:0] v;
        int           rr;
        int           cc;
        v = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                rr = row + int'(r);
                cc = col + int'(c);
                if (m[r*4+c] && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                    v[rr*COLS+cc] = 1'b1;
            end
        end
        return v;
    endfunction

    always_comb begin
        w_active    = f_render(r_mask, int'(r_row), int'(r_col));
        w_fit_spawn = f_fits(pif.piece_mask, 0, SPAWN_COL, r_grid);
        w_fit_down  = f_fits(r_mask, int'(r_row) + 1, int'(r_col), r_grid);
        w_fit_left  = f_fits(r_mask, int'(r_row), int'(r_col) - 1, r_grid);
        w_fit_right = f_fits(r_mask, int'(r_row), int'(r_col) + 1, r_grid);
        w_row_full  = &r_grid[int'(r_scan)*COLS +: COLS];
    end

    // Rows at or above scan_row slide down one; rows below it are untouched.
    always_comb begin
        w_shifted = r_grid;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (i <= 32'(r_scan)) begin
                if (i == 0)
                    w_shifted[i*COLS +: COLS] = '0;
                else
                    w_shifted[i*COLS +: COLS] = r_grid[(i-1)*COLS +: COLS];
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_grid_n  = r_grid;
        w_mask_n  = r_mask;
        w_row_n   = r_row;
        w_col_n   = r_col;
        w_drop_n  = r_drop;
        w_pend_n  = r_pend;
        w_scan_n  = r_scan;
        w_lines_n = r_lines;
        if (start) begin
            w_state_n = S_SPAWN;
            w_grid_n  = '0;
            w_mask_n  = '0;
            w_row_n   = '0;
            w_col_n   = '0;
            w_drop_n  = 1'b0;
            w_pend_n  = 1'b0;
            w_scan_n  = '0;
            w_lines_n = '0;
        end else begin
            case (r_state)
                S_SPAWN: begin
                    if (pif.piece_valid && pif.piece_mask != '0) begin
                        if (w_fit_spawn) begin
                            w_mask_n  = pif.piece_mask;
                            w_row_n   = '0;
                            w_col_n   = CW'(SPAWN_COL);
                            w_state_n = S_FALL;
                        end else begin
                            w_state_n = S_GAMEOVER;
                        end
                    end
                end
                S_FALL: begin
                    if (r_drop || drop_i) begin
                        w_drop_n = 1'b1;
                        if (w_fit_down)
                            w_row_n = r_row + RW'(1);
                        else
                            w_state_n = S_LOCK;
                    end else if (left_i ^ right_i) begin
                        // A tick colliding with a lateral move is deferred one cycle.
                        w_pend_n = r_pend | tick;
                        if (left_i && w_fit_left)
                            w_col_n = r_col - CW'(1);
                        else if (right_i && w_fit_right)
                            w_col_n = r_col + CW'(1);
                    end else if (tick || r_pend) begin
                        w_pend_n = 1'b0;
                        if (w_fit_down)
                            w_row_n = r_row + RW'(1);
                        else
                            w_state_n = S_LOCK;
                    end
                end
                S_LOCK: begin
                    w_grid_n  = r_grid | w_active;
                    w_mask_n  = '0;
                    w_row_n   = '0;
                    w_col_n   = '0;
                    w_drop_n  = 1'b0;
                    w_pend_n  = 1'b0;
                    w_scan_n  = SW'(ROWS - 1);
                    w_state_n = S_CLEAR;
                end
                S_CLEAR: begin
                    if (w_row_full) begin
                        w_grid_n = w_shifted;
                        if (r_lines != '1)
                            w_lines_n = r_lines + LINES_W'(1);
                    end else if (r_scan != '0) begin
                        w_scan_n = r_scan - SW'(1);
                    end else begin
                        w_state_n = S_SPAWN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grid  <= '0;
            r_mask  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_drop  <= 1'b0;
            r_pend  <= 1'b0;
            r_scan  <= '0;
            r_lines <= '0;
        end else begin
            r_state <= w_state_n;
            r_grid  <= w_grid_n;
            r_mask  <= w_mask_n;
            r_row   <= w_row_n;
            r_col   <= w_col_n;
            r_drop  <= w_drop_n;
            r_pend  <= w_pend_n;
            r_scan  <= w_scan_n;
            r_lines <= w_lines_n;
        end
    end

    assign display       = (r_state == S_FALL) ? (r_grid | w_active) : r_grid;
    assign lines_cleared = r_lines;
    assign gameover      = (r_state == S_GAMEOVER);
    assign state_o       = r_state;
    assign pif.piece_req = (r_state == S_SPAWN);

endmodule

// File: tb/tb_playfield_engine.sv
// Directed bench: default 20x10 field plus a 4x4 field, checked against
// hand-derived display words and cycle counts.
module tb_playfield_engine;
    logic clk = 1'b0;
    logic reset;
    logic start_a, tick_a, left_a, right_a, drop_a;
    logic start_b, tick_b, left_b, right_b, drop_b;
    logic [199:0] disp_a;
    logic [15:0]  disp_b;
    logic [15:0]  lines_a, lines_b;
    logic         go_a, go_b;
    logic [2:0]   st_a, st_b;
    logic [199:0] stored_a;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n;

    playfield_engine_if ifa ();
    playfield_engine_if ifb ();

    playfield_engine dut_a (
        .clk(clk), .reset(reset), .start(start_a), .tick(tick_a),
        .left_i(left_a), .right_i(right_a), .drop_i(drop_a), .pif(ifa),
        .display(disp_a), .lines_cleared(lines_a), .gameover(go_a), .state_o(st_a)
    );

    playfield_engine #(.ROWS(4), .COLS(4), .SPAWN_COL(0), .LINES_W(16)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tick(tick_b),
        .left_i(left_b), .right_i(right_b), .drop_i(drop_b), .pif(ifb),
        .display(disp_b), .lines_cleared(lines_b), .gameover(go_b), .state_o(st_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // 2x2 block with top-left at (r, c) on the 20x10 field.
    function automatic logic [199:0] blk(input int r, input int c);
        logic [199:0] v;
        v = '0;
        v[r*10+c]       = 1'b1;
        v[r*10+c+1]     = 1'b1;
        v[(r+1)*10+c]   = 1'b1;
        v[(r+1)*10+c+1] = 1'b1;
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        {start_a, tick_a, left_a, right_a, drop_a} = '0;
        {start_b, tick_b, left_b, right_b, drop_b} = '0;
        ifa.piece_mask = '0; ifa.piece_valid = 1'b0;
        ifb.piece_mask = '0; ifb.piece_valid = 1'b0;
        cyc(); cyc();
        check("rst_state_a", st_a, 0);
        check("rst_disp_a", disp_a, 0);
        check("rst_lines_a", lines_a, 0);
        check("rst_go_a", go_a, 0);
        check("rst_req_a", ifa.piece_req, 0);
        check("rst_state_b", st_b, 0);
        reset = 1'b0;

        // default field: spawn and gravity
        start_a = 1'b1; cyc(); start_a = 1'b0;
        check("a_spawn_state", st_a, 1);
        check("a_spawn_req", ifa.piece_req, 1);
        ifa.piece_mask = 16'h0033; ifa.piece_valid = 1'b1; cyc(); ifa.piece_valid = 1'b0;
        check("a_fall_state", st_a, 2);
        check("a_spawn_disp", disp_a, blk(0, 3));
        check("a_req_low", ifa.piece_req, 0);
        for (int i = 0; i < 18; i++) begin
            tick_a = 1'b1; cyc(); tick_a = 1'b0;
        end
        check("a_disp_18", disp_a, blk(18, 3));
        tick_a = 1'b1; cyc(); tick_a = 1'b0;
        check("a_lock", st_a, 3);
        cyc();
        n = 0;
        while (st_a == 3'd4 && n < 100) begin n++; cyc(); end
        check("a_clear_cycles", n, 20);
        check("a_respawn_state", st_a, 1);
        check("a_respawn_req", ifa.piece_req, 1);
        check("a_lines", lines_a, 0);
        stored_a = blk(18, 3);
        check("a_stored", disp_a, stored_a);

        // lateral moves
        ifa.piece_mask = 16'h0066; ifa.piece_valid = 1'b1; cyc(); ifa.piece_valid = 1'b0;
        check("a_spawn66", disp_a, stored_a | blk(0, 4));
        for (int i = 0; i < 4; i++) begin
            left_a = 1'b1; cyc(); left_a = 1'b0;
        end
        check("a_left4", disp_a, stored_a | blk(0, 0));
        left_a = 1'b1; cyc(); left_a = 1'b0;
        check("a_left_blocked", disp_a, stored_a | blk(0, 0));
        left_a = 1'b1; right_a = 1'b1; cyc(); left_a = 1'b0; right_a = 1'b0;
        check("a_both", disp_a, stored_a | blk(0, 0));
        right_a = 1'b1; cyc(); right_a = 1'b0;
        check("a_right", disp_a, stored_a | blk(0, 1));
        tick_a = 1'b1; left_a = 1'b1; cyc(); tick_a = 1'b0; left_a = 1'b0;
        check("a_tickleft_n1", disp_a, stored_a | blk(0, 0));
        cyc();
        check("a_tickleft_n2", disp_a, stored_a | blk(1, 0));

        // 4x4 field: hard drop and single line clear
        start_b = 1'b1; cyc(); start_b = 1'b0;
        ifb.piece_mask = 16'h000F; ifb.piece_valid = 1'b1; cyc(); ifb.piece_valid = 1'b0;
        check("b_spawn_disp", disp_b, 16'h000F);
        drop_b = 1'b1; cyc(); drop_b = 1'b0;
        n = 1;
        check("b_drop_step", disp_b, 16'h00F0);
        while (st_b != 3'd3 && n < 20) begin n++; cyc(); end
        check("b_drop_cycles", n, 4);
        cyc();
        n = 0;
        while (st_b == 3'd4 && n < 100) begin
            left_b = 1'b1; right_b = 1'b0; tick_b = 1'b1; drop_b = 1'b1;
            n++; cyc();
        end
        {left_b, right_b, tick_b, drop_b} = '0;
        check("b_clear_cycles", n, 5);
        check("b_clear_disp", disp_b, 0);
        check("b_lines1", lines_b, 1);
        check("b_respawn", st_b, 1);

        // zero mask ignored
        ifb.piece_mask = 16'h0000; ifb.piece_valid = 1'b1; cyc(); ifb.piece_valid = 1'b0;
        check("b_zero_state", st_b, 1);
        check("b_zero_req", ifb.piece_req, 1);

        // game over
        ifb.piece_mask = 16'h1111; ifb.piece_valid = 1'b1; cyc(); ifb.piece_valid = 1'b0;
        check("b_col_spawn", disp_b, 16'h1111);
        cyc();
        check("b_no_leak", disp_b, 16'h1111);
        tick_b = 1'b1; cyc(); tick_b = 1'b0;
        check("b_lock2", st_b, 3);
        cyc();
        n = 0;
        while (st_b == 3'd4 && n < 100) begin n++; cyc(); end
        check("b_clear2_cycles", n, 4);
        ifb.piece_valid = 1'b1; cyc(); ifb.piece_valid = 1'b0;
        check("b_go_state", st_b, 5);
        check("b_go_flag", go_b, 1);
        check("b_go_req", ifb.piece_req, 0);
        check("b_go_disp", disp_b, 16'h1111);
        start_b = 1'b1; cyc(); start_b = 1'b0;
        check("b_restart_disp", disp_b, 0);
        check("b_restart_go", go_b, 0);
        check("b_restart_state", st_b, 1);
        check("b_restart_lines", lines_b, 0);

        // reset in the middle of CLEAR
        ifb.piece_mask = 16'h000F; ifb.piece_valid = 1'b1; cyc(); ifb.piece_valid = 1'b0;
        drop_b = 1'b1; cyc(); drop_b = 1'b0;
        n = 0;
        while (st_b != 3'd3 && n < 20) begin n++; cyc(); end
        cyc(); cyc();
        check("b_mid_clear_state", st_b, 4);
        check("b_mid_clear_lines", lines_b, 1);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("b_rst_disp", disp_b, 0);
        check("b_rst_lines", lines_b, 0);
        check("b_rst_state", st_b, 0);
        check("a_rst_disp", disp_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
